// File: rtl/sha256_round_ctrl.sv
// Sequencing controller for the SHA-256 compression datapath: block handshake,
// mode strobes, round index and multi-block chain tracking.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             block_valid,
  input  logic             block_first,
  input  logic             block_last,
  input  logic             abort,
  output logic             block_ready,
  output logic             init_round,
  output logic             init_digest,
  output logic             first_block,
  output logic             partial_rounds,
  output logic             update_digest,
  output logic [5:0]       round_idx,
  output logic             w_msg_sel,
  output logic             digest_valid,
  output logic             proto_err,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_DIGEST, S_DONE} state_t;

  localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS - 1);

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             chain_open_q, chain_open_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic [5:0]       round_idx_q, round_idx_d;

  logic block_ready_q, block_ready_d;
  logic init_round_q, init_round_d;
  logic first_block_q, first_block_d;
  logic partial_q, partial_d;
  logic update_q, update_d;
  logic w_msg_sel_q, w_msg_sel_d;
  logic digest_valid_q, digest_valid_d;
  logic proto_err_q, proto_err_d;
  logic busy_q, busy_d;

  logic accept, chain_live, new_chain;

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    last_d       = last_q;
    chain_open_d = chain_open_q;
    blk_count_d  = blk_count_q;
    round_idx_d  = 6'd0;
    proto_err_d  = 1'b0;

    accept     = block_valid & block_ready_q;
    // An abort coinciding with an accept clears the chain before the block starts.
    chain_live = chain_open_q & ~abort;
    new_chain  = block_first | ~chain_live;

    case (state_q)
      S_IDLE: begin
        if (abort) begin
          chain_open_d = 1'b0;
          blk_count_d  = '0;
        end
        if (accept) begin
          state_d      = S_INIT;
          first_d      = new_chain;
          last_d       = block_last;
          proto_err_d  = ~block_first & ~chain_live;
          chain_open_d = 1'b1;
          if (new_chain) blk_count_d = '0;
        end
      end
      S_INIT: state_d = S_ROUND;
      S_ROUND: begin
        if (round_idx_q == LAST_RND) begin
          state_d     = S_DIGEST;
          blk_count_d = (blk_count_q == '1) ? blk_count_q : blk_count_q + CNT_W'(1);
        end else begin
          round_idx_d = round_idx_q + 6'd1;
        end
      end
      S_DIGEST: begin
        state_d = last_q ? S_DONE : S_IDLE;
        if (last_q) chain_open_d = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      chain_open_d = 1'b0;
      blk_count_d  = '0;
      round_idx_d  = 6'd0;
    end

    // Outputs are decoded from the next state so they line up with it.
    block_ready_d  = (state_d == S_IDLE);
    init_round_d   = (state_d == S_INIT);
    first_block_d  = (state_d == S_INIT) & first_d;
    partial_d      = (state_d == S_ROUND);
    update_d       = (state_d == S_DIGEST);
    digest_valid_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
    w_msg_sel_d    = (state_d == S_ROUND) && (round_idx_d < 6'd16);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      chain_open_q   <= 1'b0;
      blk_count_q    <= '0;
      round_idx_q    <= 6'd0;
      block_ready_q  <= 1'b0;
      init_round_q   <= 1'b0;
      first_block_q  <= 1'b0;
      partial_q      <= 1'b0;
      update_q       <= 1'b0;
      w_msg_sel_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      proto_err_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_q        <= first_d;
      last_q         <= last_d;
      chain_open_q   <= chain_open_d;
      blk_count_q    <= blk_count_d;
      round_idx_q    <= round_idx_d;
      block_ready_q  <= block_ready_d;
      init_round_q   <= init_round_d;
      first_block_q  <= first_block_d;
      partial_q      <= partial_d;
      update_q       <= update_d;
      w_msg_sel_q    <= w_msg_sel_d;
      digest_valid_q <= digest_valid_d;
      proto_err_q    <= proto_err_d;
      busy_q         <= busy_d;
    end
  end

  assign block_ready    = block_ready_q;
  assign init_round     = init_round_q;
  assign init_digest    = init_round_q;
  assign first_block    = first_block_q;
  assign partial_rounds = partial_q;
  assign update_digest  = update_q;
  assign round_idx      = round_idx_q;
  assign w_msg_sel      = w_msg_sel_q;
  assign digest_valid   = digest_valid_q;
  assign proto_err      = proto_err_q;
  assign busy           = busy_q;
  assign blk_count      = blk_count_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: full-length build plus a 2-round build.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        block_valid = 0, block_first = 0, block_last = 0, abort = 0;
  logic        block_ready, init_round, init_digest, first_block, partial_rounds;
  logic        update_digest, w_msg_sel, digest_valid, proto_err, busy;
  logic [5:0]  round_idx;
  logic [15:0] blk_count;

  logic        v2 = 0, f2 = 0, l2 = 0, ab2 = 0;
  logic        rdy2, ir2, id2, fb2, pr2, ud2, wm2, dv2, pe2, bz2;
  logic [5:0]  ri2;
  logic [15:0] bc2;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;

  sha256_round_ctrl #(.NUM_ROUNDS(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .block_valid(block_valid), .block_first(block_first),
    .block_last(block_last), .abort(abort), .block_ready(block_ready),
    .init_round(init_round), .init_digest(init_digest), .first_block(first_block),
    .partial_rounds(partial_rounds), .update_digest(update_digest),
    .round_idx(round_idx), .w_msg_sel(w_msg_sel), .digest_valid(digest_valid),
    .proto_err(proto_err), .busy(busy), .blk_count(blk_count));

  sha256_round_ctrl #(.NUM_ROUNDS(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .block_valid(v2), .block_first(f2), .block_last(l2),
    .abort(ab2), .block_ready(rdy2), .init_round(ir2), .init_digest(id2),
    .first_block(fb2), .partial_rounds(pr2), .update_digest(ud2), .round_idx(ri2),
    .w_msg_sel(wm2), .digest_valid(dv2), .proto_err(pe2), .busy(bz2), .blk_count(bc2));

  always @(negedge clk) if (digest_valid) dv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, block_ready, 0);
    chk({tag, ".init"}, {init_round, init_digest, first_block}, 0);
    chk({tag, ".strobes"}, {partial_rounds, update_digest, digest_valid, proto_err}, 0);
    chk({tag, ".ridx"}, {round_idx, w_msg_sel, busy}, 0);
    chk({tag, ".cnt"}, blk_count, 0);
  endtask

  // One full block from IDLE back to IDLE; called at a negedge while IDLE.
  task automatic do_block(input logic f, input logic l, input logic keep,
                          input logic exp_fb, input logic exp_pe,
                          input logic [15:0] c0, input logic [15:0] c1);
    block_valid = 1; block_first = f; block_last = l;
    tick;
    abort = 0;
    if (!keep) block_valid = 0;
    chk("init.strobes", {init_round, init_digest, partial_rounds, update_digest}, 4'b1100);
    chk("init.first_block", first_block, exp_fb);
    chk("init.proto_err", proto_err, exp_pe);
    chk("init.blk_count", blk_count, c0);
    chk("init.ready_busy", {block_ready, busy}, 2'b01);
    for (int i = 0; i < 64; i++) begin
      tick;
      chk("round.strobes", {init_round, partial_rounds, update_digest, proto_err}, 4'b0100);
      chk("round.idx", round_idx, i);
      chk("round.w_msg_sel", w_msg_sel, (i < 16));
    end
    block_valid = 0;
    tick;
    chk("digest.strobes", {init_round, partial_rounds, update_digest}, 3'b001);
    chk("digest.blk_count", blk_count, c1);
    chk("digest.ridx", round_idx, 0);
    if (l) begin
      tick;
      chk("done.valid", {digest_valid, update_digest, busy, block_ready}, 4'b1010);
      chk("done.blk_count", blk_count, c1);
    end
    tick;
    chk("idle.ready", {block_ready, busy, digest_valid}, 3'b100);
  endtask

  initial begin
    tick;
    chk_all_zero("reset");
    rst = 0;
    tick;
    chk("post_reset.ready", {block_ready, busy}, 2'b10);

    // Single-block message.
    do_block(1, 1, 0, 1, 0, 16'd0, 16'd1);
    chk("single.dv_cnt", dv_cnt, 1);

    // Two-block chain, back to back; valid held high through the first block.
    do_block(1, 0, 1, 1, 0, 16'd0, 16'd1);
    do_block(0, 1, 0, 0, 0, 16'd1, 16'd2);
    chk("chain.dv_cnt", dv_cnt, 2);

    // Continuation with no open chain, then a mid-chain restart.
    do_block(0, 0, 0, 1, 1, 16'd0, 16'd1);
    do_block(1, 0, 0, 1, 0, 16'd0, 16'd1);

    // Abort at round 30 of a continuation block.
    block_valid = 1; block_first = 0; block_last = 1;
    tick;
    block_valid = 0;
    chk("abort.init_fb", {first_block, blk_count}, {1'b0, 16'd1});
    for (int i = 0; i <= 30; i++) tick;
    chk("abort.at_idx", round_idx, 30);
    abort = 1;
    tick;
    abort = 0;
    chk("abort.strobes", {init_round, partial_rounds, update_digest, digest_valid}, 0);
    chk("abort.idle", {block_ready, busy, round_idx}, {1'b1, 1'b0, 6'd0});
    chk("abort.blk_count", blk_count, 0);
    tick;
    chk("abort.no_digest", {digest_valid, block_ready}, 2'b01);
    chk("abort.dv_cnt", dv_cnt, 2);

    // Chain was closed by the abort.
    do_block(0, 0, 0, 1, 1, 16'd0, 16'd1);
    // Abort together with accept: chain cleared first, so forced first + error.
    abort = 1;
    do_block(0, 0, 0, 1, 1, 16'd0, 16'd1);

    // Asynchronous reset mid-round.
    block_valid = 1; block_first = 0; block_last = 1;
    tick;
    block_valid = 0;
    for (int i = 0; i <= 10; i++) tick;
    chk("arst.pre_idx", {partial_rounds, round_idx}, {1'b1, 6'd10});
    rst = 1;
    #1;
    chk_all_zero("arst");
    tick;
    rst = 0;
    tick;
    chk("arst.ready", {block_ready, blk_count}, {1'b1, 16'd0});
    do_block(1, 1, 0, 1, 0, 16'd0, 16'd1);
    chk("final.dv_cnt", dv_cnt, 3);

    // Reduced-round build.
    v2 = 1; f2 = 1; l2 = 1;
    tick;
    v2 = 0;
    chk("r2.init", {ir2, id2, fb2, pr2, pe2}, 5'b11100);
    tick;
    chk("r2.round0", {pr2, ri2, wm2}, {1'b1, 6'd0, 1'b1});
    tick;
    chk("r2.round1", {pr2, ri2}, {1'b1, 6'd1});
    tick;
    chk("r2.digest", {pr2, ud2, bc2}, {2'b01, 16'd1});
    tick;
    chk("r2.done", {dv2, rdy2}, 2'b10);
    tick;
    chk("r2.idle", {rdy2, bz2, dv2}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
